cmac_rx_ernic_bridge: RTL and testbench

//  Receive-side counterpart of the CMAC TX packet path. Takes the CMAC USPLUS RX AXIS stream (512b, no backpressure) on
//  the CMAC user clock and stores each frame in a store-and-forward FIFO. Frames with errors, bad framing or overflow
//  are dropped. Good frames go to the ERNIC RX AXIS input with tready backpressure. Keeps per-frame statistics.

---
 rtl/cmac_rx_ernic_bridge.sv | 175 +++++++++++++++++
 tb/tb_cmac_rx_ernic_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_rx_ernic_bridge.sv
// Store-and-forward bridge from the CMAC RX AXIS stream to the ERNIC RX AXIS input, dropping bad or oversized frames.
// Optional feature macro RX_ERR_FRAME_FWD_EN: forward tuser=1 frames with m_axis_tuser set on their tlast beat.
module cmac_rx_ernic_bridge #(
  parameter  int DATA_W        = 512,
  parameter  int FIFO_DEPTH    = 64,
  parameter  int MAX_PKT_BEATS = 32,
  parameter  int CNT_W         = 32,
  localparam int KEEP_W        = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              rx_axis_tvalid,
  input  logic [DATA_W-1:0] rx_axis_tdata,
  input  logic [KEEP_W-1:0] rx_axis_tkeep,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic [CNT_W-1:0]  stat_good_pkts,
  output logic [CNT_W-1:0]  stat_bad_pkts,
  output logic [CNT_W-1:0]  stat_drop_pkts,
  output logic [CNT_W-1:0]  stat_good_bytes,
  output logic              fifo_ovf_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(MAX_PKT_BEATS + 2);

`ifdef RX_ERR_FRAME_FWD_EN
  localparam logic ERR_FWD = 1'b1;
  localparam int   EW      = DATA_W + KEEP_W + 2;
`else
  localparam logic ERR_FWD = 1'b0;
  localparam int   EW      = DATA_W + KEEP_W + 1;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_W-1:0] k);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + CNT_W'(k[i]);
    return n;
  endfunction

  typedef enum logic [1:0] {SYNC, IDLE, WRITE, DROP} wr_state_t;

  wr_state_t     wr_state;
  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
  logic [BW-1:0] beat_cnt;
  logic          frm_bad;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] wr_word, rd_word;

  logic [PW-1:0] used;
  logic [BW-1:0] beat_num;
  logic          fifo_full, in_frame, beat_ovf, beat_long, beat_bad, frm_bad_n, drop_beat;
  logic          rd_avail, rd_load;

  // Write-side qualification of the current input beat
  assign used      = wr_ptr - rd_ptr;
  assign fifo_full = (used == PW'(FIFO_DEPTH));
  assign in_frame  = rx_axis_tvalid && ((wr_state == IDLE) || (wr_state == WRITE));
  assign beat_num  = (wr_state == WRITE) ? beat_cnt + 1'b1 : BW'(1);
  assign beat_ovf  = in_frame && fifo_full;
  assign beat_long = in_frame && (beat_num > BW'(MAX_PKT_BEATS));
  assign drop_beat = beat_ovf || beat_long;
  assign beat_bad  = rx_axis_tlast ? (rx_axis_tkeep == '0) : !(&rx_axis_tkeep);
  assign frm_bad_n = ((wr_state == WRITE) && frm_bad) || beat_bad;

`ifdef RX_ERR_FRAME_FWD_EN
  assign wr_word = {rx_axis_tuser & rx_axis_tlast, rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};
`else
  assign wr_word = {rx_axis_tlast, rx_axis_tkeep, rx_axis_tdata};
  assign m_axis_tuser = 1'b0;
`endif

  // Storage is written speculatively; rollback only moves wr_ptr back to wr_commit
  always_ff @(posedge aclk) begin
    if (in_frame && !drop_beat)
      mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state        <= SYNC;
      wr_ptr          <= '0;
      wr_commit       <= '0;
      beat_cnt        <= '0;
      frm_bad         <= 1'b0;
      stat_good_pkts  <= '0;
      stat_bad_pkts   <= '0;
      stat_drop_pkts  <= '0;
      stat_good_bytes <= '0;
      fifo_ovf_sticky <= 1'b0;
    end else if (rx_axis_tvalid) begin
      case (wr_state)
        SYNC: if (rx_axis_tlast) wr_state <= IDLE;
        DROP: if (rx_axis_tlast) wr_state <= IDLE;
        default: begin
          if (drop_beat) begin
            // Overflow/length beats the commit, even on the tlast beat
            wr_ptr         <= wr_commit;
            stat_drop_pkts <= sat_inc(stat_drop_pkts);
            if (beat_ovf) fifo_ovf_sticky <= 1'b1;
            wr_state       <= rx_axis_tlast ? IDLE : DROP;
          end else if (rx_axis_tlast) begin
            wr_state <= IDLE;
            if (frm_bad_n || (rx_axis_tuser && !ERR_FWD)) begin
              wr_ptr        <= wr_commit;
              stat_bad_pkts <= sat_inc(stat_bad_pkts);
            end else begin
              wr_ptr    <= wr_ptr + 1'b1;
              wr_commit <= wr_ptr + 1'b1;
              if (rx_axis_tuser) begin
                stat_bad_pkts <= sat_inc(stat_bad_pkts);
              end else begin
                stat_good_pkts  <= sat_inc(stat_good_pkts);
                stat_good_bytes <= sat_add(stat_good_bytes,
                                           CNT_W'(KEEP_W) * CNT_W'(beat_num - 1'b1) + popcount(rx_axis_tkeep));
              end
            end
          end else begin
            wr_ptr   <= wr_ptr + 1'b1;
            beat_cnt <= beat_num;
            frm_bad  <= frm_bad_n;
            wr_state <= WRITE;
          end
        end
      endcase
    end
  end

  // Read side: committed data only, one output register in first-word-fall-through style
  assign rd_avail = (rd_ptr != wr_commit);
  assign rd_load  = rd_avail && (!m_axis_tvalid || m_axis_tready);
  assign rd_word  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef RX_ERR_FRAME_FWD_EN
      m_axis_tuser  <= 1'b0;
`endif
    end else if (rd_load) begin
      rd_ptr        <= rd_ptr + 1'b1;
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= rd_word[DATA_W-1:0];
      m_axis_tkeep  <= rd_word[DATA_W +: KEEP_W];
      m_axis_tlast  <= rd_word[DATA_W+KEEP_W];
`ifdef RX_ERR_FRAME_FWD_EN
      m_axis_tuser  <= rd_word[EW-1];
`endif
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmac_rx_ernic_bridge.sv
// Bench for cmac_rx_ernic_bridge: directed scenarios and randomized frames scored against a frame-level model.
// Define RX_ERR_FRAME_FWD_EN on both bench and design to cover the error-frame forwarding build.
`timescale 1ns/1ps
module tb_cmac_rx_ernic_bridge;
  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int MAX_PKT_BEATS = 32;
  localparam int CNT_W = 32;
`ifdef RX_ERR_FRAME_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              rx_axis_tvalid = 1'b0;
  logic [DATA_W-1:0] rx_axis_tdata = '0;
  logic [KEEP_W-1:0] rx_axis_tkeep = '0;
  logic              rx_axis_tlast = 1'b0;
  logic              rx_axis_tuser = 1'b0;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [CNT_W-1:0]  stat_good_pkts, stat_bad_pkts, stat_drop_pkts, stat_good_bytes;
  logic              fifo_ovf_sticky;

  cmac_rx_ernic_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .stat_good_pkts(stat_good_pkts), .stat_bad_pkts(stat_bad_pkts), .stat_drop_pkts(stat_drop_pkts),
    .stat_good_bytes(stat_good_bytes), .fifo_ovf_sticky(fifo_ovf_sticky)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              user;
  } beat_t;

  beat_t frm[$];
  beat_t exp_q[$];
  beat_t rcv_q[$];
  beat_t mb;
  int    n_vec = 0, n_fail = 0;
  int    rdy_mode = 0;
  int    exp_good = 0, exp_bad = 0, exp_drop = 0, exp_bytes = 0;
  logic  exp_ovf = 1'b0;
  logic  hold_pend = 1'b0;
  logic [DATA_W+KEEP_W+1:0] hold_val;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  // ERNIC-side ready pattern: 0 hold low, 1 hold high, otherwise random with 75% duty
  always @(posedge aclk) begin
    #2;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(3, 0) != 0);
    endcase
  end

  // Collect accepted output beats and check that a stalled beat stays put
  always @(negedge aclk) begin
    if (hold_pend)
      chk("axis_hold", 640'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
          640'({1'b1, hold_val}));
    hold_pend = aresetn && m_axis_tvalid && !m_axis_tready;
    hold_val  = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      mb.data = m_axis_tdata;
      mb.keep = m_axis_tkeep;
      mb.last = m_axis_tlast;
      mb.user = m_axis_tuser;
      rcv_q.push_back(mb);
    end
  end

  task automatic build_frame(input int len, input bit user);
    beat_t b;
    int nb, rem;
    frm.delete();
    nb = (len + KEEP_W - 1) / KEEP_W;
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < DATA_W / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.last = (i == nb - 1);
      b.keep = '1;
      if (b.last) begin
        rem = len - i * KEEP_W;
        if (rem != KEEP_W) b.keep = (64'd1 << rem) - 64'd1;
      end
      b.user = b.last ? user : 1'($urandom_range(1, 0));
      frm.push_back(b);
    end
  endtask

  // Frame-level reference: decide the fate of the whole frame from its length, keeps and error flag
  task automatic model_frame();
    bit    bad;
    int    len;
    beat_t b;
    bad = 1'b0;
    len = 0;
    if (frm.size() > MAX_PKT_BEATS) begin
      exp_drop++;
      return;
    end
    foreach (frm[i]) begin
      if (frm[i].last) bad = bad | (frm[i].keep == '0);
      else             bad = bad | (frm[i].keep != '1);
      len += $countones(frm[i].keep);
    end
    if (bad || (frm[frm.size()-1].user && !FWD)) begin
      exp_bad++;
      return;
    end
    if (frm[frm.size()-1].user) exp_bad++;
    else begin
      exp_good++;
      exp_bytes += len;
    end
    foreach (frm[i]) begin
      b = frm[i];
      b.user = b.last && b.user;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_beat(input beat_t b);
    rx_axis_tvalid = 1'b1;
    rx_axis_tdata  = b.data;
    rx_axis_tkeep  = b.keep;
    rx_axis_tlast  = b.last;
    rx_axis_tuser  = b.user;
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frm[i]) begin
      if (gaps && $urandom_range(7, 0) == 0) begin
        rx_axis_tvalid = 1'b0;
        tick();
      end
      drive_beat(frm[i]);
      tick();
    end
    rx_axis_tvalid = 1'b0;
  endtask

  task automatic wait_room(input int lim);
    int t;
    t = 0;
    while ((exp_q.size() - rcv_q.size() > lim) && t < 5000) begin
      tick();
      t++;
    end
    chk("room", 640'(exp_q.size() - rcv_q.size() <= lim), 640'(1));
  endtask

  task automatic drain_check(input string tag);
    int t;
    t = 0;
    while (rcv_q.size() < exp_q.size() && t < 20000) begin
      tick();
      t++;
    end
    repeat (8) tick();
    chk({tag, "_beats"}, 640'(rcv_q.size()), 640'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      chk({tag, "_data"}, 640'(rcv_q[i].data), 640'(exp_q[i].data));
      chk({tag, "_ctl"}, 640'({rcv_q[i].keep, rcv_q[i].last, rcv_q[i].user}),
          640'({exp_q[i].keep, exp_q[i].last, exp_q[i].user}));
    end
    exp_q.delete();
    rcv_q.delete();
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_good"},  640'(stat_good_pkts),  640'(exp_good));
    chk({tag, "_bad"},   640'(stat_bad_pkts),   640'(exp_bad));
    chk({tag, "_drop"},  640'(stat_drop_pkts),  640'(exp_drop));
    chk({tag, "_bytes"}, 640'(stat_good_bytes), 640'(exp_bytes));
    chk({tag, "_ovf"},   640'(fifo_ovf_sticky), 640'(exp_ovf));
  endtask

  task automatic reset_sync();
    rx_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    repeat (2) tick();
    aresetn = 1'b1;
    tick();
    exp_good = 0; exp_bad = 0; exp_drop = 0; exp_bytes = 0; exp_ovf = 1'b0;
    build_frame(128, 1'b0);
    send_frame(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [KEEP_W-1:0] k;
    int kind;

    // Reset state
    aresetn = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    chk("rst_tvalid", 640'(m_axis_tvalid), 640'(0));
    chk("rst_payload", 640'({m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata}), 640'(0));
    chk_stats("rst");
    rdy_mode = 1;
    reset_sync();
    drain_check("sync");
    chk_stats("sync");

    // 9-beat frame ending in 10 bytes, first beat of output two cycles after the tlast beat
    build_frame(8 * 64 + 10, 1'b0);
    model_frame();
    send_frame(1'b0);
    @(negedge aclk);
    chk("t1_lat_t1", 640'(m_axis_tvalid), 640'(0));
    tick();
    @(negedge aclk);
    chk("t1_lat_t2", 640'(m_axis_tvalid), 640'(1));
    drain_check("t1");
    chk_stats("t1");
    chk("t1_bytes522", 640'(stat_good_bytes), 640'(522));

    // Errored frame followed by a single-beat good frame
    build_frame(3 * 64, 1'b1);
    model_frame();
    send_frame(1'b0);
    build_frame(40, 1'b0);
    model_frame();
    send_frame(1'b0);
    drain_check("t2");
    chk_stats("t2");

    // Stalled output: short frame, then two 32-beat frames; the second overflows on its tlast beat
    rdy_mode = 0;
    repeat (2) tick();
    build_frame(100, 1'b0);
    model_frame();
    send_frame(1'b0);
    build_frame(32 * 64, 1'b0);
    model_frame();
    send_frame(1'b0);
    build_frame(32 * 64, 1'b0);
    exp_drop++;
    exp_ovf = 1'b1;
    send_frame(1'b0);
    repeat (4) tick();
    @(negedge aclk);
    chk("t3_stall_vld", 640'(m_axis_tvalid), 640'(1));
    chk_stats("t3");
    rdy_mode = 1;
    drain_check("t3");

    // 33-beat frame dropped on length, next frame unaffected
    build_frame(33 * 64, 1'b0);
    model_frame();
    send_frame(1'b0);
    build_frame(200, 1'b0);
    model_frame();
    send_frame(1'b0);
    drain_check("t4");
    chk_stats("t4");

    // Reset in the middle of a frame, released while the frame is still arriving
    build_frame(10 * 64, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == 4) aresetn = 1'b0;
      if (i == 6) aresetn = 1'b1;
      drive_beat(frm[i]);
      tick();
    end
    rx_axis_tvalid = 1'b0;
    exp_good = 0; exp_bad = 0; exp_drop = 0; exp_bytes = 0; exp_ovf = 1'b0;
    exp_q.delete();
    rcv_q.delete();
    repeat (3) tick();
    @(negedge aclk);
    chk("t5_tvalid", 640'(m_axis_tvalid), 640'(0));
    chk_stats("t5_rst");
    build_frame(300, 1'b0);
    model_frame();
    send_frame(1'b0);
    drain_check("t5");
    chk_stats("t5");

    // 1000 good frames of 64..1500 bytes with random ready and input gaps
    reset_sync();
    drain_check("t6_sync");
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      wait_room(24);
      build_frame($urandom_range(1500, 64), 1'b0);
      model_frame();
      send_frame(1'b1);
    end
    drain_check("t6");
    chk_stats("t6");
    chk("t6_good1000", 640'(stat_good_pkts), 640'(1000));

    // Mixed random frames: good, errored, bad middle keep, empty last keep, oversized
    for (int f = 0; f < 150; f++) begin
      wait_room(24);
      kind = $urandom_range(3, 0);
      build_frame($urandom_range(2200, 1), kind == 1);
      if (kind == 2 && frm.size() > 1) begin
        k = '1;
        k = k >> $urandom_range(63, 1);
        frm[$urandom_range(frm.size() - 2, 0)].keep = k;
      end
      if (kind == 3) frm[frm.size()-1].keep = '0;
      model_frame();
      send_frame(1'b1);
    end
    drain_check("t7");
    chk_stats("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
